// File: rtl/pc_pkg.sv
// Shared types for the program counter and its clients.
package pc_pkg;

    // Overflow behaviour on increment: modulo wrap or clamp at all-ones.
    typedef enum logic {
        PC_WRAP = 1'b0,
        PC_SAT  = 1'b1
    } pc_ovf_mode_t;

endpackage

// File: rtl/inc_n.sv
// Constant-step incrementer: sum_o = {carry, a_i + STEP}, evaluated in WIDTH+1 bits.
module inc_n #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned STEP  = 1
) (
    input  logic [WIDTH-1:0] a_i,
    output logic [WIDTH:0]   sum_o
);

    // STEP is truncated to WIDTH+1 bits; the top-level check keeps it below 2**WIDTH.
    localparam logic [WIDTH:0] StepW = (WIDTH+1)'(STEP);

    // Zero-extend the operand so the MSB of the result is the carry out.
    always_comb begin
        sum_o = {1'b0, a_i} + StepW;
    end

endmodule

// File: rtl/pc_counter.sv
// Program counter: registered address with reset, stall, load (jump) and constant-step
// increment, plus a one-cycle overflow flag aligned with the value it describes.
module pc_counter
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH       = 16,
    parameter int unsigned      STEP        = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter pc_ovf_mode_t     OVF_MODE    = PC_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             inc,
    output logic [WIDTH-1:0] out,
    output logic             ovf
);

    // Reject parameter combinations the adder cannot represent.
    if (WIDTH < 2) begin : g_bad_width
        $fatal(1, "pc_counter: WIDTH must be at least 2");
    end
    if (STEP == 0 || (WIDTH < 32 && 64'(STEP) >= (64'd1 << WIDTH))) begin : g_bad_step
        $fatal(1, "pc_counter: STEP must be in 1 .. 2**WIDTH-1");
    end

    logic [WIDTH-1:0] out_q, out_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   inc_sum;
    logic             carry;

    inc_n #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_inc (
        .a_i   (out_q),
        .sum_o (inc_sum)
    );

    assign carry = inc_sum[WIDTH];

    // Priority mux: stall > load > inc > hold; reset is applied in the register.
    always_comb begin
        out_d = out_q;
        ovf_d = 1'b0;
        if (stall) begin
            out_d = out_q;
        end else if (load) begin
            out_d = load_value;
        end else if (inc) begin
            if (OVF_MODE == PC_SAT && carry) begin
                out_d = '1;
            end else begin
                out_d = inc_sum[WIDTH-1:0];
            end
            ovf_d = carry;
        end
    end

    // State register with synchronous reset that overrides every control input.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= RESET_VALUE;
            ovf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            ovf_q <= ovf_d;
        end
    end

    assign out = out_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_pc_counter.sv
// Scoreboard bench: three counters (16-bit step 1 wrap, 4-bit step 3 wrap, 4-bit step 3
// saturate) share one control stream; a behavioural model pushes expected results per edge.
module tb_pc_counter;
    import pc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        load = 1'b0;
    logic        inc = 1'b0;
    logic [15:0] lv = 16'h0;

    logic [15:0] out16;
    logic        ovf16;
    logic [3:0]  outw, outs;
    logic        ovfw, ovfs;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_counter #(
        .WIDTH (16), .STEP (1), .RESET_VALUE (16'h0000), .OVF_MODE (PC_WRAP)
    ) u_dut16 (
        .clk (clk), .rst (rst), .stall (stall), .load (load), .load_value (lv),
        .inc (inc), .out (out16), .ovf (ovf16)
    );

    pc_counter #(
        .WIDTH (4), .STEP (3), .RESET_VALUE (4'h0), .OVF_MODE (PC_WRAP)
    ) u_dut_wrap (
        .clk (clk), .rst (rst), .stall (stall), .load (load), .load_value (lv[3:0]),
        .inc (inc), .out (outw), .ovf (ovfw)
    );

    pc_counter #(
        .WIDTH (4), .STEP (3), .RESET_VALUE (4'h0), .OVF_MODE (PC_SAT)
    ) u_dut_sat (
        .clk (clk), .rst (rst), .stall (stall), .load (load), .load_value (lv[3:0]),
        .inc (inc), .out (outs), .ovf (ovfs)
    );

    typedef struct packed {
        logic [15:0] out16;
        logic        ovf16;
        logic [3:0]  outw;
        logic        ovfw;
        logic [3:0]  outs;
        logic        ovfs;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m16 = 32'h0;
    logic [31:0] mw  = 32'h0;
    logic [31:0] ms  = 32'h0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: returns {ovf, next_out}.
    function automatic logic [32:0] model_step(
        input logic [31:0] cur, input int unsigned w, input int unsigned step, input bit sat,
        input bit r, input bit s, input bit l, input bit i, input logic [31:0] lval
    );
        logic [31:0] mask;
        logic [32:0] sum;
        logic        cy;
        mask = (32'd1 << w) - 32'd1;
        if (r) return {1'b0, 32'h0};
        if (s) return {1'b0, cur};
        if (l) return {1'b0, lval & mask};
        if (i) begin
            sum = {1'b0, cur} + 33'(step);
            cy  = sum[w];
            if (cy && sat) return {1'b1, mask};
            return {cy, sum[31:0] & mask};
        end
        return {1'b0, cur};
    endfunction

    task automatic compare();
        exp_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty: got empty queue expected an entry");
            return;
        end
        n_checks--;
        e = sb_q.pop_front();
        check_eq("out16", 32'(out16), 32'(e.out16));
        check_eq("ovf16", 32'(ovf16), 32'(e.ovf16));
        check_eq("out_wrap", 32'(outw), 32'(e.outw));
        check_eq("ovf_wrap", 32'(ovfw), 32'(e.ovfw));
        check_eq("out_sat", 32'(outs), 32'(e.outs));
        check_eq("ovf_sat", 32'(ovfs), 32'(e.ovfs));
    endtask

    task automatic drive(input bit r, input bit s, input bit l, input bit i,
                         input logic [15:0] val);
        exp_t        e;
        logic [32:0] n;
        @(negedge clk);
        rst = r; stall = s; load = l; inc = i; lv = val;
        n = model_step(m16, 16, 1, 1'b0, r, s, l, i, {16'h0, val});
        m16 = n[31:0]; e.out16 = n[15:0]; e.ovf16 = n[32];
        n = model_step(mw, 4, 3, 1'b0, r, s, l, i, {28'h0, val[3:0]});
        mw = n[31:0]; e.outw = n[3:0]; e.ovfw = n[32];
        n = model_step(ms, 4, 3, 1'b1, r, s, l, i, {28'h0, val[3:0]});
        ms = n[31:0]; e.outs = n[3:0]; e.ovfs = n[32];
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare();
    endtask

    initial begin
        logic [15:0] v;
        // Reset wins over load and inc.
        drive(1, 0, 1, 1, 16'h1234);
        check_eq("rst_out16_const", 32'(out16), 32'h0);
        // Three increments from zero.
        drive(0, 0, 0, 1, 16'h0);
        drive(0, 0, 0, 1, 16'h0);
        drive(0, 0, 0, 1, 16'h0);
        check_eq("inc3_out16_const", 32'(out16), 32'h3);
        // Load beats inc, then stall holds.
        drive(0, 0, 1, 1, 16'h00FF);
        drive(0, 1, 0, 1, 16'h0);
        check_eq("stall_out16_const", 32'(out16), 32'h00FF);
        // 4-bit overflow: load E, inc, inc, idle.
        drive(0, 0, 1, 0, 16'h000E);
        drive(0, 0, 0, 1, 16'h0);
        check_eq("wrap_out_const", 32'(outw), 32'h1);
        check_eq("sat_out_const", 32'(outs), 32'hF);
        check_eq("sat_ovf_const", 32'(ovfs), 32'h1);
        drive(0, 0, 0, 1, 16'h0);
        check_eq("wrap_ovf_clear_const", 32'(ovfw), 32'h0);
        check_eq("sat_ovf_again_const", 32'(ovfs), 32'h1);
        drive(0, 0, 0, 0, 16'h0);
        // 16-bit wrap at all-ones.
        drive(0, 0, 1, 0, 16'hFFFF);
        drive(0, 0, 0, 1, 16'h0);
        check_eq("wrap16_ovf_const", 32'(ovf16), 32'h1);
        // Random control and data against the model.
        for (int k = 0; k < 1000; k++) begin
            v = 16'($urandom);
            if ($urandom_range(3) == 0) v = 16'hFFFF - 16'($urandom_range(3));
            drive($urandom_range(49) == 0, $urandom_range(4) == 0, $urandom_range(4) == 0,
                  $urandom_range(1) == 0, v);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
